if_id_skid_reg: RTL and testbench

IF/ID pipeline boundary directly downstream of the PC register and instruction memory. It captures each fetched {pc, instr} beat and presents it to the decode stage over a valid/ready handshake. A 2-entry skid buffer lets the fetch side run at full rate while ID back-pressure stays registered. A synchronous flush discards wrong-path instructions on branch/jump redirect.

---
 rtl/if_id_skid_reg.sv | 187 ++++++++++++++++++
 tb/tb_if_id_skid_reg.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_skid_reg
//  Purpose  : IF/ID pipeline boundary with a 2-entry skid buffer. Captures
//             each fetched {pc, instr} beat and presents it to decode over a
//             valid/ready handshake. in_ready is registered so ID-side
//             back-pressure never forms a combinational path to fetch.
//             A synchronous flush drops all buffered (wrong-path) beats.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    XLEN       width of pc and instruction words
//    NOP_INSTR  instruction shown on out_instr while out_valid = 0
//  Ports
//    clk        clock, rising-edge active
//    rst_n      asynchronous active-low reset
//    in_valid   fetch beat valid          in_pc / in_instr  fetch payload
//    in_ready   buffer can accept (registered)
//    out_valid  decode beat valid         out_pc / out_instr decode payload
//    out_ready  decode consumes the beat
//    flush      discard all buffered beats (redirect / exception)
//  Optional feature (macro IF_ID_PERF_EN)
//    stall_cnt  cycles with in_valid & !in_ready & !flush (wraps at 2^32)
//    flush_cnt  cycles with flush asserted (wraps at 2^32)
// ============================================================================
module if_id_skid_reg #(
   parameter int               XLEN      = 32,
   parameter logic [XLEN-1:0]  NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_instr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_instr,
   input  logic            flush
`ifdef IF_ID_PERF_EN
   ,
   output logic [31:0]     stall_cnt,
   output logic [31:0]     flush_cnt
`endif
);

   // Occupancy state: EMPTY = nothing held, HALF = main only,
   // FULL = main plus skid. main_valid/skid_valid are implied by it.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_HALF  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            r_in_ready;

   logic [XLEN-1:0] r_main_pc;
   logic [XLEN-1:0] r_main_instr;
   logic [XLEN-1:0] r_skid_pc;
   logic [XLEN-1:0] r_skid_instr;

   logic            w_main_valid;
   logic            w_accept;
   logic            w_drain;
   logic            w_ld_main_in;
   logic            w_ld_main_skid;
   logic            w_ld_skid;

   assign w_main_valid = (r_state != ST_EMPTY);
   assign w_accept     = in_valid & r_in_ready;
   assign w_drain      = w_main_valid & out_ready;

   // ------------------------------------------------------------------
   // Next-state and payload-load decode
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt    = r_state;
      w_ld_main_in   = 1'b0;
      w_ld_main_skid = 1'b0;
      w_ld_skid      = 1'b0;

      if (flush) begin
         // A beat accepted this cycle is dropped; upstream still sees its
         // handshake complete. A same-cycle drain was already taken by ID.
         w_state_nxt = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  w_state_nxt  = ST_HALF;
                  w_ld_main_in = 1'b1;
               end
            end
            ST_HALF: begin
               if (w_accept && w_drain) begin
                  w_ld_main_in = 1'b1;
               end else if (w_accept) begin
                  w_state_nxt = ST_FULL;
                  w_ld_skid   = 1'b1;
               end else if (w_drain) begin
                  w_state_nxt = ST_EMPTY;
               end
            end
            ST_FULL: begin
               // in_ready is low here, so only a drain can move us.
               if (w_drain) begin
                  w_state_nxt    = ST_HALF;
                  w_ld_main_skid = 1'b1;
               end
            end
            default: begin
               w_state_nxt = ST_EMPTY;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // State and registered ready
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_EMPTY;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         // Ready looks only at where we are going, never at out_ready
         // directly, so the fetch side sees a flop output.
         r_in_ready <= (w_state_nxt != ST_FULL);
      end
   end

   // ------------------------------------------------------------------
   // Payload registers: load only on their own load strobe
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main_pc    <= '0;
         r_main_instr <= '0;
         r_skid_pc    <= '0;
         r_skid_instr <= '0;
      end else begin
         if (w_ld_main_in) begin
            r_main_pc    <= in_pc;
            r_main_instr <= in_instr;
         end else if (w_ld_main_skid) begin
            r_main_pc    <= r_skid_pc;
            r_main_instr <= r_skid_instr;
         end
         if (w_ld_skid) begin
            r_skid_pc    <= in_pc;
            r_skid_instr <= in_instr;
         end
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = w_main_valid;
   assign out_pc    = r_main_pc;
   assign out_instr = w_main_valid ? r_main_instr : NOP_INSTR;

   // ------------------------------------------------------------------
   // Optional performance counters
   // ------------------------------------------------------------------
`ifdef IF_ID_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (in_valid && !r_in_ready && !flush) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         if (flush) begin
            flush_cnt <= flush_cnt + 32'd1;
         end
      end
   end
`else
   // Performance counters not built; datapath is unchanged.
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_id_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_id_skid_reg
//  Purpose  : Self-checking bench for if_id_skid_reg. A queue-based model
//             of the buffer (FIFO of beats, depth 2, registered ready)
//             predicts every output; directed scenarios are followed by a
//             randomized run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_skid_reg;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_pc;
   logic [31:0] in_instr;
   logic        out_ready;
   logic        flush;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
`ifdef IF_ID_PERF_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
`endif

   if_id_skid_reg #(.XLEN(32), .NOP_INSTR(NOP)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pc     (in_pc),
      .in_instr  (in_instr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_instr (out_instr),
      .flush     (flush)
`ifdef IF_ID_PERF_EN
      ,
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } beat_t;

   beat_t       m_q[$];
   logic        m_ready;
   logic [31:0] m_stall;
   logic [31:0] m_flush;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_ready = 1'b1;
      m_stall = '0;
      m_flush = '0;
   endtask

   // One clock edge of the buffer as a FIFO of depth 2.
   task automatic model_edge(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                             input logic ordy, input logic fl);
      bit    acc;
      bit    drn;
      beat_t b;
      acc = v && m_ready;
      drn = (m_q.size() > 0) && ordy;
      if (v && !m_ready && !fl) m_stall = m_stall + 32'd1;
      if (fl) m_flush = m_flush + 32'd1;
      if (fl) begin
         m_q.delete();
      end else begin
         if (drn) void'(m_q.pop_front());
         if (acc) begin
            b.pc    = pc;
            b.instr = ins;
            m_q.push_back(b);
         end
      end
      m_ready = (m_q.size() < 2);
   endtask

   task automatic check_outputs();
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_q.size() > 0});
      chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
      if (m_q.size() > 0) begin
         chk("out_pc", out_pc, m_q[0].pc);
         chk("out_instr", out_instr, m_q[0].instr);
      end else begin
         chk("out_instr_nop", out_instr, NOP);
      end
`ifdef IF_ID_PERF_EN
      chk("stall_cnt", stall_cnt, m_stall);
      chk("flush_cnt", flush_cnt, m_flush);
`endif
   endtask

   // Called just after a falling edge: drive, confirm ready is not
   // combinationally affected, advance model, check after the next edge.
   task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic ordy, input logic fl);
      in_valid  = v;
      in_pc     = pc;
      in_instr  = ins;
      out_ready = ordy;
      flush     = fl;
      #1;
      chk("in_ready_pre", {31'd0, in_ready}, {31'd0, m_ready});
      model_edge(v, pc, ins, ordy, fl);
      @(negedge clk);
      check_outputs();
   endtask

   initial begin
      logic [31:0] pc_gen;

      // ---------------- reset with in_valid held high ----------------
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_pc     = 32'h0;
      in_instr  = 32'h0050_0093;
      out_ready = 1'b0;
      flush     = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_instr", out_instr, 32'h0000_0013);
      chk("rst_out_pc", out_pc, 32'h0);
      step(1'b1, 32'h0, 32'h0050_0093, 1'b1, 1'b0);
      chk("first_beat_pc", out_pc, 32'h0);

      // ---------------- streaming ----------------
      step(1'b1, 32'h4, 32'h0010_0113, 1'b1, 1'b0);
      step(1'b1, 32'h8, 32'h0020_0193, 1'b1, 1'b0);
      step(1'b1, 32'hC, 32'h0030_0213, 1'b1, 1'b0);
      chk("stream_last_pc", out_pc, 32'hC);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // ---------------- back-pressure ----------------
      step(1'b1, 32'h10, 32'h1111_0001, 1'b0, 1'b0);
      step(1'b1, 32'h14, 32'h1111_0002, 1'b0, 1'b0);
      chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
      step(1'b1, 32'h18, 32'h1111_0003, 1'b0, 1'b0);
      chk("bp_hold_pc", out_pc, 32'h10);
      step(1'b1, 32'h18, 32'h1111_0003, 1'b1, 1'b0);
      chk("bp_second_pc", out_pc, 32'h14);
      step(1'b1, 32'h18, 32'h1111_0003, 1'b1, 1'b0);
      chk("bp_third_pc", out_pc, 32'h18);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // ---------------- flush in FULL with accept attempt ----------------
      step(1'b1, 32'h20, 32'h2222_0001, 1'b0, 1'b0);
      step(1'b1, 32'h24, 32'h2222_0002, 1'b0, 1'b0);
      step(1'b1, 32'h28, 32'h2222_0003, 1'b0, 1'b1);
      chk("flush_nop", out_instr, NOP);
      step(1'b1, 32'h100, 32'h3333_0001, 1'b0, 1'b0);
      chk("post_flush_pc", out_pc, 32'h100);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("post_flush_alone", {31'd0, out_valid}, 32'd0);

      // ---------------- async reset mid-cycle in HALF ----------------
      step(1'b1, 32'h200, 32'h4444_0001, 1'b0, 1'b0);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_out_valid", {31'd0, out_valid}, 32'd0);
      chk("async_in_ready", {31'd0, in_ready}, 32'd1);
      chk("async_out_instr", out_instr, NOP);
      chk("async_out_pc", out_pc, 32'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      check_outputs();

      // ---------------- counters: 3 stalls, 2 flushes ----------------
      step(1'b1, 32'h300, 32'h5555_0001, 1'b0, 1'b0);
      step(1'b1, 32'h304, 32'h5555_0002, 1'b0, 1'b0);
      repeat (3) step(1'b1, 32'h308, 32'h5555_0003, 1'b0, 1'b0);
      step(1'b1, 32'h308, 32'h5555_0003, 1'b0, 1'b1);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
`ifdef IF_ID_PERF_EN
      chk("perf_stall3", stall_cnt, 32'd3);
      chk("perf_flush2", flush_cnt, 32'd2);
`endif

      // ---------------- randomized run ----------------
      pc_gen = 32'h1000;
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 99) < 70), pc_gen, $urandom,
              ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 5));
         pc_gen = pc_gen + 32'd4;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
